// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Request/response bundle between the pipeline MEM stage (master) and the
//   data memory responder (slave).
//   req_valid/req_ready : request handshake, accepted when both are high
//   req_write           : 1 = store, 0 = load
//   req_addr/req_wdata  : byte address and store data
//   resp_valid          : one-cycle response strobe
//   resp_rdata/resp_err : load data and fault flag, qualified by resp_valid
//   stall               : request outstanding, pipeline must hold
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-outstanding load/store responder backed by a DEPTH x 64-bit array.
//   A request is captured on acceptance, held for WAIT_CYCLES wait states and
//   answered with a one-cycle response; stores commit on the edge leaving RESP.
//   Ports:
//     Clk     : rising-edge clock
//     Reset_n : asynchronous active-low reset (array contents are not cleared)
//     bus     : data_mem_responder_if slave modport
//
//   state | meaning
//   IDLE  | ready for a request, no stall
//   WAIT  | request captured, wait counter running, stall asserted
//   RESP  | response strobe driven, store commits on exit, stall asserted
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic                  Clk,
  input logic                  Reset_n,
  data_mem_responder_if.slave  bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [63:0] LIMIT    = 64'(DEPTH) << 3;
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        accept;
  logic        fault;
  logic [AW-1:0] idx;

  // Zero at time 0 only; reset deliberately leaves the contents alone.
  logic [63:0] mem [DEPTH] = '{default: '0};

  assign accept = (state == S_IDLE) && bus.req_valid;
  assign idx    = addr_q[AW+2:3];
  // Full-width compare so high address bits never alias into the array.
  assign fault  = (addr_q[2:0] != 3'd0) || (addr_q >= LIMIT);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (accept) begin
        cnt     <= CNT_LOAD;
        wr_q    <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == S_IDLE);
    bus.stall      = (state != S_IDLE);
    bus.resp_valid = (state == S_RESP);
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    if (state == S_RESP) begin
      bus.resp_err = fault;
      if (!wr_q && !fault) bus.resp_rdata = mem[idx];
    end
  end

  // A reset during RESP forces IDLE asynchronously, so a pending store is dropped.
  always_ff @(posedge Clk) begin
    if ((state == S_RESP) && wr_q && !fault) mem[idx] <= wdata_q;
  end

endmodule
